// File: rtl/periph_pkg.sv
// Shared definitions for the memory-mapped peripheral block: window geometry,
// register offsets and TCON bit positions.
package periph_pkg;

    localparam logic [31:0] BASE_ADDR_DEFAULT = 32'h4000_0000;
    localparam logic [31:0] WINDOW_SIZE       = 32'h0000_0018;

    localparam logic [4:0] OFF_TH      = 5'h00;
    localparam logic [4:0] OFF_TL      = 5'h04;
    localparam logic [4:0] OFF_TCON    = 5'h08;
    localparam logic [4:0] OFF_LEDS    = 5'h0C;
    localparam logic [4:0] OFF_DIGITS  = 5'h10;
    localparam logic [4:0] OFF_SYSTICK = 5'h14;

    localparam int TCON_EN = 0;  // timer enable
    localparam int TCON_IE = 1;  // irq enable
    localparam int TCON_IP = 2;  // irq pending

endpackage

// File: rtl/periph_timer.sv
// Reloadable 32-bit timer: TL counts up while enabled and reloads from TH on
// overflow, optionally latching an interrupt-pending flag.
module periph_timer
    import periph_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_th,
    input  logic        wr_tl,
    input  logic        wr_tcon,
    input  logic [31:0] wdata,
    output logic [31:0] th,
    output logic [31:0] tl,
    output logic [2:0]  tcon
);

    logic overflow;
    logic irq_set;

    assign overflow = tcon[TCON_EN] && (tl == 32'hFFFF_FFFF);
    assign irq_set  = overflow && tcon[TCON_IE];

    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values, which is what makes the write/overflow races resolve cleanly.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            th   <= '0;
            tl   <= '0;
            tcon <= '0;
        end else begin
            if (wr_th)
                th <= wdata;

            // A CPU store to TL beats both the increment and the reload.
            if (wr_tl)
                tl <= wdata;
            else if (tcon[TCON_EN])
                tl <= overflow ? th : tl + 32'd1;

            // Hardware setting of the pending bit wins over a CPU clear in the same cycle.
            if (wr_tcon) begin
                tcon[TCON_EN] <= wdata[TCON_EN];
                tcon[TCON_IE] <= wdata[TCON_IE];
                tcon[TCON_IP] <= wdata[TCON_IP] | irq_set;
            end else if (irq_set) begin
                tcon[TCON_IP] <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/periph_bus.sv
// Peripheral window on the CPU memory bus: address decode, read mux, LED and
// seven-segment registers, free-running SYSTICK and the embedded timer.
module periph_bus
    import periph_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Address,
    input  logic [31:0] Write_data,
    input  logic        MemRead,
    input  logic        MemWrite,
    output logic [31:0] Read_data,
    output logic        Periph_sel,
    output logic [7:0]  leds,
    output logic [11:0] digits,
    output logic        irq
);

    logic [31:0] offset;
    logic [4:0]  reg_off;
    logic        wr;
    logic [31:0] th;
    logic [31:0] tl;
    logic [2:0]  tcon;
    logic [31:0] systick;

    // Subtract first so a window at the very top of the address map cannot wrap.
    assign offset     = Address - BASE_ADDR;
    assign Periph_sel = (Address >= BASE_ADDR) && (offset < WINDOW_SIZE);
    assign reg_off    = {offset[4:2], 2'b00};
    assign wr         = MemWrite && Periph_sel;

    periph_timer u_timer (
        .clk     (clk),
        .reset   (reset),
        .wr_th   (wr && (reg_off == OFF_TH)),
        .wr_tl   (wr && (reg_off == OFF_TL)),
        .wr_tcon (wr && (reg_off == OFF_TCON)),
        .wdata   (Write_data),
        .th      (th),
        .tl      (tl),
        .tcon    (tcon)
    );

    assign irq = tcon[TCON_IP];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            leds    <= '0;
            digits  <= '0;
            systick <= '0;
        end else begin
            systick <= systick + 32'd1;
            if (wr && (reg_off == OFF_LEDS))
                leds <= Write_data[7:0];
            if (wr && (reg_off == OFF_DIGITS))
                digits <= Write_data[11:0];
        end
    end

    // Read path only sees registers, never Write_data.
    // NOTE: Read_data gets a default before the case so no latch is inferred.
    always_comb begin
        Read_data = 32'h0;
        if (MemRead && Periph_sel) begin
            case (reg_off)
                OFF_TH:      Read_data = th;
                OFF_TL:      Read_data = tl;
                OFF_TCON:    Read_data = {29'h0, tcon};
                OFF_LEDS:    Read_data = {24'h0, leds};
                OFF_DIGITS:  Read_data = {20'h0, digits};
                OFF_SYSTICK: Read_data = systick;
                default:     Read_data = 32'h0;
            endcase
        end
    end

endmodule

// File: tb/tb_periph_bus.sv
// Directed bench for periph_bus: bus reads/writes with hand-computed expected
// values for timer reload, interrupt races, decode limits and reset.
`timescale 1ns/1ps
module tb_periph_bus;

    localparam logic [31:0] BASE = 32'h4000_0000;
    localparam logic [31:0] A_TH      = BASE + 32'h00;
    localparam logic [31:0] A_TL      = BASE + 32'h04;
    localparam logic [31:0] A_TCON    = BASE + 32'h08;
    localparam logic [31:0] A_LEDS    = BASE + 32'h0C;
    localparam logic [31:0] A_DIGITS  = BASE + 32'h10;
    localparam logic [31:0] A_SYSTICK = BASE + 32'h14;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Address;
    logic [31:0] Write_data;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] Read_data;
    logic        Periph_sel;
    logic [7:0]  leds;
    logic [11:0] digits;
    logic        irq;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] cyc;
    logic [31:0] d;

    always #5 clk = ~clk;

    // Reference cycle count for SYSTICK.
    always @(posedge clk or negedge reset) begin
        if (!reset) cyc <= '0;
        else        cyc <= cyc + 32'd1;
    end

    periph_bus #(.BASE_ADDR(BASE)) dut (
        .clk        (clk),
        .reset      (reset),
        .Address    (Address),
        .Write_data (Write_data),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .Read_data  (Read_data),
        .Periph_sel (Periph_sel),
        .leds       (leds),
        .digits     (digits),
        .irq        (irq)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One-cycle store; returns just after the following falling edge.
    task automatic do_write(input logic [31:0] a, input logic [31:0] wd);
        Address    = a;
        Write_data = wd;
        MemWrite   = 1'b1;
        @(posedge clk);
        #1;
        MemWrite   = 1'b0;
        @(negedge clk);
    endtask

    // Combinational read; consumes 1 ns and no clock edge.
    task automatic read_reg(input logic [31:0] a, output logic [31:0] rd);
        Address = a;
        MemRead = 1'b1;
        #1;
        rd      = Read_data;
        MemRead = 1'b0;
    endtask

    initial begin
        reset = 1'b0; Address = '0; Write_data = '0; MemRead = 1'b0; MemWrite = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_leds", {24'h0, leds}, 32'h0);
        check("rst_digits", {20'h0, digits}, 32'h0);
        check("rst_irq", {31'h0, irq}, 32'h0);
        read_reg(A_TCON, d);    check("rst_rd_tcon", d, 32'h0);
        read_reg(A_TL, d);      check("rst_rd_tl", d, 32'h0);

        // SYSTICK counts 0,1,2 on successive cycles after release.
        reset = 1'b1;
        read_reg(A_SYSTICK, d); check("systick0", d, 32'd0);
        @(negedge clk);
        read_reg(A_SYSTICK, d); check("systick1", d, 32'd1);
        @(negedge clk);
        read_reg(A_SYSTICK, d); check("systick2", d, 32'd2);

        // Overflow with reload and interrupt.
        do_write(A_TH, 32'hFFFF_FFFC);
        do_write(A_TL, 32'hFFFF_FFFE);
        do_write(A_TCON, 32'h3);
        read_reg(A_TL, d);      check("ovf_tl0", d, 32'hFFFF_FFFE);
        @(negedge clk);
        read_reg(A_TL, d);      check("ovf_tl1", d, 32'hFFFF_FFFF);
        check("ovf_irq_pre", {31'h0, irq}, 32'h0);
        @(negedge clk);
        read_reg(A_TL, d);      check("ovf_reload", d, 32'hFFFF_FFFC);
        check("ovf_irq", {31'h0, irq}, 32'h1);
        @(negedge clk);

        // CPU clears pending; counting continues through the write.
        do_write(A_TCON, 32'h3);
        check("clr_irq", {31'h0, irq}, 32'h0);
        read_reg(A_TL, d);      check("clr_tl", d, 32'hFFFF_FFFE);
        read_reg(A_TCON, d);    check("clr_tcon", d, 32'h3);
        @(negedge clk);

        // CPU write to TL on the overflow cycle wins, irq still sets.
        do_write(A_TL, 32'd5);
        read_reg(A_TL, d);      check("race_tl", d, 32'd5);
        check("race_tl_irq", {31'h0, irq}, 32'h1);
        read_reg(A_TCON, d);    check("race_tl_tcon", d, 32'h7);

        // CPU write to TCON on the overflow cycle: pending bit set by hardware.
        do_write(A_TCON, 32'h3);
        do_write(A_TL, 32'hFFFF_FFFF);
        do_write(A_TCON, 32'h3);
        read_reg(A_TCON, d);    check("race_tcon", d, 32'h7);
        read_reg(A_TL, d);      check("race_tcon_tl", d, 32'hFFFF_FFFC);

        // Disabled timer holds TL and pending bit.
        do_write(A_TCON, 32'h2);
        repeat (3) @(negedge clk);
        read_reg(A_TL, d);      check("hold_tl", d, 32'hFFFF_FFFD);
        check("hold_irq", {31'h0, irq}, 32'h0);

        // New TH leaves TL alone and is used at the next reload; IE=0 suppresses irq.
        do_write(A_TH, 32'h10);
        read_reg(A_TL, d);      check("th_keeps_tl", d, 32'hFFFF_FFFD);
        read_reg(A_TH, d);      check("th_rd", d, 32'h10);
        do_write(A_TL, 32'hFFFF_FFFF);
        do_write(A_TCON, 32'h1);
        @(negedge clk);
        read_reg(A_TL, d);      check("new_th_reload", d, 32'h10);
        check("noie_irq", {31'h0, irq}, 32'h0);
        do_write(A_TCON, 32'h0);

        // LEDs, out-of-window store, decode limits.
        do_write(A_LEDS, 32'hA5);
        do_write(BASE + 32'h18, 32'hFF);
        check("leds", {24'h0, leds}, 32'hA5);
        Address = BASE + 32'h18; MemRead = 1'b1; #1;
        check("sel_18", {31'h0, Periph_sel}, 32'h0);
        check("rd_18", Read_data, 32'h0);
        MemRead = 1'b0;
        Address = BASE + 32'h17; #1;
        check("sel_17", {31'h0, Periph_sel}, 32'h1);
        Address = BASE - 32'h4; #1;
        check("sel_below", {31'h0, Periph_sel}, 32'h0);
        Address = A_LEDS; #1;
        check("rd_no_memread", Read_data, 32'h0);

        do_write(A_DIGITS, 32'hFFFF_F123);
        check("digits", {20'h0, digits}, 32'h123);
        read_reg(A_DIGITS, d);  check("rd_digits", d, 32'h123);

        // Simultaneous read and write returns the pre-edge value.
        Address = A_LEDS; Write_data = 32'h3C; MemRead = 1'b1; MemWrite = 1'b1;
        #1;
        check("rw_pre", Read_data, 32'hA5);
        Write_data = 32'h55; #1;
        check("rw_no_wd_path", Read_data, 32'hA5);
        Write_data = 32'h3C;
        @(posedge clk);
        #1;
        MemRead = 1'b0; MemWrite = 1'b0;
        check("rw_post", {24'h0, leds}, 32'h3C);
        @(negedge clk);

        // SYSTICK is read-only.
        do_write(A_SYSTICK, 32'h0);
        read_reg(A_SYSTICK, d); check("systick_ro", d, cyc);

        // Asynchronous reset mid-count.
        do_write(A_TCON, 32'h7);
        do_write(A_TL, 32'd100);
        check("pre_rst_irq", {31'h0, irq}, 32'h1);
        reset = 1'b0;
        #1;
        check("arst_irq", {31'h0, irq}, 32'h0);
        check("arst_leds", {24'h0, leds}, 32'h0);
        check("arst_digits", {20'h0, digits}, 32'h0);
        read_reg(A_TL, d);      check("arst_tl", d, 32'h0);
        read_reg(A_TH, d);      check("arst_th", d, 32'h0);
        read_reg(A_TCON, d);    check("arst_tcon", d, 32'h0);
        read_reg(A_SYSTICK, d); check("arst_systick", d, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        read_reg(A_TL, d);      check("post_rst_idle", d, 32'h0);
        do_write(A_TCON, 32'h1);
        @(negedge clk);
        read_reg(A_TL, d);      check("post_rst_count", d, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
